// File: rtl/reg_file_32x32.sv
// MIPS register file: two combinational operand ports, one registered debug port, saturating write counter.
// Latency: writes commit on the next edge, rd1/rd2 same cycle, dbg_d one cycle; no backpressure, every cycle is accepted.
module reg_file_32x32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    input  logic [ADDR_W-1:0] dbg_a,
    output logic [DATA_W-1:0] dbg_d,
    output logic [15:0]       wr_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              commit;

    // Guarding on we first keeps an undriven wa from reaching the array when idle.
    assign commit = we && (wa != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wa] <= wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_d  <= '0;
            wr_cnt <= '0;
        end else begin
            dbg_d <= (dbg_a == '0) ? '0 : regs[dbg_a];
            if (commit && (wr_cnt != 16'hFFFF)) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            if (BYPASS && commit && (ra1 == wa)) begin
                rd1 = wd;
            end else begin
                rd1 = regs[ra1];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            if (BYPASS && commit && (ra2 == wa)) begin
                rd2 = wd;
            end else begin
                rd2 = regs[ra2];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
// Bench for reg_file_32x32: bypass and non-bypass instances share inputs and are checked against an array model.
module tb_reg_file_32x32;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa, dbg_a;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd1_b, rd2_b, dbg_b, rd1_n, rd2_n, dbg_n;
    logic [15:0] cnt_b, cnt_n;

    logic [31:0] m [32];
    logic [31:0] dbg_exp;
    int unsigned cnt_exp;
    int          n_chk;
    int          n_fail;

    reg_file_32x32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .wa(wa), .wd(wd), .we(we), .dbg_a(dbg_a), .dbg_d(dbg_b), .wr_cnt(cnt_b)
    );

    reg_file_32x32 #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nob (
        .clk(clk), .rst_n(rst_n), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
        .wa(wa), .wd(wd), .we(we), .dbg_a(dbg_a), .dbg_d(dbg_n), .wr_cnt(cnt_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && we && (wa != 5'd0) && (a == wa)) return wd;
        return m[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        dbg_exp = 32'h0;
        cnt_exp = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        chk("rd1_byp", rd1_b, exp_rd(ra1, 1'b1));
        chk("rd2_byp", rd2_b, exp_rd(ra2, 1'b1));
        chk("rd1_nob", rd1_n, exp_rd(ra1, 1'b0));
        chk("rd2_nob", rd2_n, exp_rd(ra2, 1'b0));
        chk("dbg_byp", dbg_b, dbg_exp);
        chk("dbg_nob", dbg_n, dbg_exp);
        chk("cnt_byp", {16'h0, cnt_b}, cnt_exp);
        chk("cnt_nob", {16'h0, cnt_n}, cnt_exp);
        @(posedge clk);
        dbg_exp = (dbg_a == 5'd0) ? 32'h0 : m[dbg_a];
        if (we && wa != 5'd0) begin
            m[wa] = wd;
            if (cnt_exp < 65535) cnt_exp++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        we = 1'b1;
        wa = 5'(a);
        wd = d;
        step();
        we = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        we = 1'b0; wa = 5'd0; wd = 32'h0;
        ra1 = 5'd0; ra2 = 5'd0; dbg_a = 5'd0;
        model_clear();
        @(negedge clk);
        ra1 = 5'd9;
        #1;
        chk("rst_rd1", rd1_b, 32'h0);
        chk("rst_dbg", dbg_b, 32'h0);
        chk("rst_cnt", {16'h0, cnt_b}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous clear in the middle of a cycle.
        wr(5, 32'hDEADBEEF);
        ra1 = 5'd5;
        dbg_a = 5'd5;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd1", rd1_b, 32'h0);
        chk("arst_cnt", {16'h0, cnt_b}, 32'h0);
        chk("arst_dbg", dbg_b, 32'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Write to $0 is ignored.
        ra1 = 5'd0;
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        step();
        we = 1'b0;
        step();
        chk("zero_cnt", {16'h0, cnt_b}, 32'h0);

        // Same-cycle bypass on both ports.
        wr(7, 32'hAAAA5555);
        ra1 = 5'd7; ra2 = 5'd7;
        we = 1'b1; wa = 5'd7; wd = 32'h12345678;
        #1;
        chk("byp_rd1", rd1_b, 32'h12345678);
        chk("byp_rd2", rd2_b, 32'h12345678);
        chk("nob_rd1_pre", rd1_n, 32'hAAAA5555);
        chk("nob_rd2_pre", rd2_n, 32'hAAAA5555);
        step();
        we = 1'b0;
        #1;
        chk("nob_rd1_post", rd1_n, 32'h12345678);
        chk("nob_rd2_post", rd2_n, 32'h12345678);
        step();

        // Fill and sweep.
        do_reset();
        for (int i = 1; i < 32; i++) wr(i, 32'(i) * 32'h01010101);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            dbg_a = 5'(i);
            step();
        end
        step();
        chk("wrcnt31", {16'h0, cnt_b}, 32'd31);

        // Debug snapshot sees pre-edge contents.
        wr(3, 32'h0BADF00D);
        we = 1'b1; wa = 5'd3; wd = 32'hC0FFEE00; dbg_a = 5'd3;
        step();
        we = 1'b0;
        #1;
        chk("dbg_old", dbg_b, 32'h0BADF00D);
        step();
        #1;
        chk("dbg_new", dbg_b, 32'hC0FFEE00);
        step();

        // Random traffic, including an undriven write address while idle.
        for (int n = 0; n < 400; n++) begin
            we = ($urandom_range(0, 2) != 0);
            wa = 5'($urandom_range(0, 31));
            if (!we && $urandom_range(0, 1) == 1) wa = 5'bxxxxx;
            wd = $urandom;
            ra1 = (n % 5 == 0 && we) ? wa : 5'($urandom_range(0, 31));
            ra2 = 5'($urandom_range(0, 31));
            dbg_a = 5'($urandom_range(0, 31));
            step();
        end
        we = 1'b0;
        wa = 5'd0;

        // Counter saturation.
        do_reset();
        for (int n = 0; n < 65540; n++) begin
            we = 1'b1;
            wa = 5'($urandom_range(1, 31));
            wd = $urandom;
            ra1 = 5'($urandom_range(0, 31));
            ra2 = wa;
            dbg_a = 5'($urandom_range(0, 31));
            step();
            if (n == 65533) chk("cnt_65534", {16'h0, cnt_b}, 32'd65534);
        end
        we = 1'b0;
        step();
        chk("cnt_sat_byp", {16'h0, cnt_b}, 32'h0000FFFF);
        chk("cnt_sat_nob", {16'h0, cnt_n}, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
